// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B on Q(INT.FRACT) complex words.
// Stages: twiddle products -> complex product combine -> add/sub outputs, with a sticky overflow flag.
module butterfly_pipe #(
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 8,
    parameter int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_re,
    input  logic [DATA_WIDTH-1:0] a_im,
    input  logic [DATA_WIDTH-1:0] b_re,
    input  logic [DATA_WIDTH-1:0] b_im,
    input  logic [DATA_WIDTH-1:0] w_re,
    input  logic [DATA_WIDTH-1:0] w_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] x_re,
    output logic [DATA_WIDTH-1:0] x_im,
    output logic [DATA_WIDTH-1:0] y_re,
    output logic [DATA_WIDTH-1:0] y_im,
    input  logic                  ovf_clr,
    output logic                  ovf_sticky
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW;

    // Sign-magnitude multiply; slicing the signed product floors toward -inf.
    function automatic logic [DW-1:0] fx_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW-1:0] mx;
        logic [DW-1:0] my;
        logic [PW-1:0] mag;
        logic [PW-1:0] prod;
        logic          neg;
        mx   = x[DW-1] ? -x : x;
        my   = y[DW-1] ? -y : y;
        mag  = PW'(mx) * PW'(my);
        neg  = x[DW-1] ^ y[DW-1];
        prod = neg ? -mag : mag;
        return prod[FRACT_WIDTH +: DW];
    endfunction

    function automatic logic add_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic [DW-1:0] s);
        return (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
    endfunction

    function automatic logic sub_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic [DW-1:0] d);
        return (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
    endfunction

    logic          ce;
    logic          v1_reg, v2_reg, v3_reg;
    logic [DW-1:0] a_in    [2];
    logic [DW-1:0] a1_reg  [2];
    logic [DW-1:0] a2_reg  [2];
    logic [DW-1:0] p_rr_next, p_ii_next, p_ri_next, p_ir_next;
    logic [DW-1:0] p_rr_reg, p_ii_reg, p_ri_reg, p_ir_reg;
    logic [DW-1:0] wb_next [2];
    logic [DW-1:0] wb_reg  [2];
    logic [DW-1:0] x_next  [2];
    logic [DW-1:0] y_next  [2];
    logic [DW-1:0] x_reg   [2];
    logic [DW-1:0] y_reg   [2];
    logic [1:0]    ovf2;
    logic [1:0]    ovf3;
    logic          ovf_set;
    logic          ovf_reg;

    // A single global enable: every stage, including empty ones, moves only when the output can drain.
    assign ce       = ~v3_reg | out_ready;
    assign in_ready = ce;

    assign a_in[0] = a_re;
    assign a_in[1] = a_im;

    assign p_rr_next = fx_mul(w_re, b_re);
    assign p_ii_next = fx_mul(w_im, b_im);
    assign p_ri_next = fx_mul(w_re, b_im);
    assign p_ir_next = fx_mul(w_im, b_re);

    assign wb_next[0] = p_rr_reg - p_ii_reg;
    assign wb_next[1] = p_ri_reg + p_ir_reg;
    assign ovf2[0]    = sub_ovf(p_rr_reg, p_ii_reg, wb_next[0]);
    assign ovf2[1]    = add_ovf(p_ri_reg, p_ir_reg, wb_next[1]);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_addsub
            assign x_next[gi] = a2_reg[gi] + wb_reg[gi];
            assign y_next[gi] = a2_reg[gi] - wb_reg[gi];
            assign ovf3[gi]   = add_ovf(a2_reg[gi], wb_reg[gi], x_next[gi])
                              | sub_ovf(a2_reg[gi], wb_reg[gi], y_next[gi]);
        end
    endgenerate

    // Only real items flag overflow; bubbles moving through a stage are ignored.
    assign ovf_set = ce & ((v1_reg & (|ovf2)) | (v2_reg & (|ovf3)));

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg  <= 1'b0;
            v2_reg  <= 1'b0;
            v3_reg  <= 1'b0;
            ovf_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                x_reg[i] <= '0;
                y_reg[i] <= '0;
            end
        end else begin
            if (ce) begin
                v1_reg <= in_valid;
                v2_reg <= v1_reg;
                v3_reg <= v2_reg;
            end
            if (ce && v2_reg) begin
                for (int i = 0; i < 2; i++) begin
                    x_reg[i] <= x_next[i];
                    y_reg[i] <= y_next[i];
                end
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // Datapath registers need no reset: their contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (ce && in_valid) begin
            p_rr_reg <= p_rr_next;
            p_ii_reg <= p_ii_next;
            p_ri_reg <= p_ri_next;
            p_ir_reg <= p_ir_next;
            for (int i = 0; i < 2; i++) begin
                a1_reg[i] <= a_in[i];
            end
        end
        if (ce && v1_reg) begin
            for (int i = 0; i < 2; i++) begin
                wb_reg[i] <= wb_next[i];
                a2_reg[i] <= a1_reg[i];
            end
        end
    end

    assign out_valid  = v3_reg;
    assign x_re       = x_reg[0];
    assign x_im       = x_reg[1];
    assign y_re       = y_reg[0];
    assign y_im       = y_reg[1];
    assign ovf_sticky = ovf_reg;

endmodule
